// File: rtl/projection_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : projection_receiver
//  Purpose  : Ping-pong projection buffer. The calculator fills the write
//             page while the previous event drains from the read page over a
//             valid/ready stream; start swaps the pages.
//  Revision : 1.0 - initial release
// ============================================================================
module projection_receiver #(
   parameter int ADDR_BITS = 6,
   parameter int DATA_BITS = 54
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 wr_en,
   input  logic [8:0]           write_projection,
   input  logic [DATA_BITS-1:0] projection_calc,
   output logic [DATA_BITS-1:0] proj_data,
   output logic                 proj_valid,
   input  logic                 proj_ready,
   output logic                 proj_last,
   output logic                 overflow,
   output logic                 dropped
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] FULL = {1'b1, {ADDR_BITS{1'b0}}};

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   // Both pages live in one array; the MSB of the index selects the page.
   logic [DATA_BITS-1:0] mem [0:2*DEPTH-1];

   logic [0:0]         state;
   logic               wr_page;
   logic               rd_page;
   logic [ADDR_BITS:0] wr_count;
   logic [ADDR_BITS:0] wr_count_next;
   logic [ADDR_BITS:0] rd_count;
   logic [ADDR_BITS:0] next_addr;
   logic               in_range;
   logic               wr_accept;
   logic               last_handshake;

   assign rd_page        = ~wr_page;
   assign in_range       = (write_projection >> ADDR_BITS) == 9'd0;
   assign wr_accept      = wr_en && in_range;
   assign last_handshake = proj_valid && proj_ready && proj_last;

   // Write counter including this cycle's write, so a write coinciding with
   // start is counted in the outgoing event.
   always_comb begin
      wr_count_next = wr_count;
      if (wr_accept && (wr_count != FULL)) begin
         wr_count_next = wr_count + 1'b1;
      end
   end

   // Memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[{wr_page, write_projection[ADDR_BITS-1:0]}] <= projection_calc;
      end
   end

   // Write-side bookkeeping: page select, entry counter, sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_page  <= 1'b0;
         wr_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en && !in_range) begin
            overflow <= 1'b1;
         end
         if (start) begin
            wr_page  <= ~wr_page;
            wr_count <= '0;
         end else begin
            wr_count <= wr_count_next;
         end
      end
   end

   // Drain FSM: output register doubles as the synchronous read register and
   // only reloads when empty or when its current word is being accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rd_count   <= '0;
         next_addr  <= '0;
         proj_data  <= '0;
         proj_valid <= 1'b0;
         proj_last  <= 1'b0;
         dropped    <= 1'b0;
      end else if (start) begin
         // A start while entries remain abandons them; a start landing on
         // the final handshake is a clean hand-over, not a drop.
         dropped    <= (state == DRAIN) && !last_handshake;
         rd_count   <= wr_count_next;
         next_addr  <= '0;
         proj_valid <= 1'b0;
         proj_last  <= 1'b0;
         state      <= (wr_count_next != '0) ? DRAIN : IDLE;
      end else begin
         dropped <= 1'b0;
         if ((state == DRAIN) && (!proj_valid || proj_ready)) begin
            if (next_addr < rd_count) begin
               proj_data  <= mem[{rd_page, next_addr[ADDR_BITS-1:0]}];
               proj_valid <= 1'b1;
               proj_last  <= (next_addr + 1'b1) == rd_count;
               next_addr  <= next_addr + 1'b1;
            end else begin
               proj_valid <= 1'b0;
               proj_last  <= 1'b0;
               state      <= IDLE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_projection_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_projection_receiver
//  Purpose  : Self-checking bench for projection_receiver. A queue-based
//             event model predicts the output stream; directed scenarios
//             pin the model with literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_projection_receiver;

   localparam int AB = 6;
   localparam int DB = 54;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          wr_en;
   logic [8:0]    write_projection;
   logic [DB-1:0] projection_calc;
   logic [DB-1:0] proj_data;
   logic          proj_valid;
   logic          proj_ready;
   logic          proj_last;
   logic          overflow;
   logic          dropped;

   projection_receiver #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .wr_en            (wr_en),
      .write_projection (write_projection),
      .projection_calc  (projection_calc),
      .proj_data        (proj_data),
      .proj_valid       (proj_valid),
      .proj_ready       (proj_ready),
      .proj_last        (proj_last),
      .overflow         (overflow),
      .dropped          (dropped)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [DB-1:0] mdl_mem [2][64];
   logic [DB-1:0] exp_q [$];
   logic [DB-1:0] log_d [$];
   logic          log_l [$];
   int            wp = 0;
   int            cnt = 0;
   logic          exp_ovf = 1'b0;
   logic          exp_drop = 1'b0;
   int            drop_count = 0;
   logic          prev_stall = 1'b0;
   logic [DB-1:0] prev_data;
   logic          prev_last;
   int            wait_cnt = 0;

   // Compare outputs against the model, then fold this cycle's inputs in.
   always @(negedge clk) begin
      if (reset) begin
         check("rst_valid", proj_valid, 0);
         check("rst_last", proj_last, 0);
         check("rst_overflow", overflow, 0);
         check("rst_dropped", dropped, 0);
         check("rst_data", proj_data, 0);
         exp_q.delete();
         wp = 0; cnt = 0; exp_ovf = 1'b0; exp_drop = 1'b0;
         prev_stall = 1'b0; wait_cnt = 0;
      end else begin
         check("overflow", overflow, exp_ovf);
         check("dropped", dropped, exp_drop);
         if (dropped) drop_count++;
         if (prev_stall)
            check("stall_hold", {proj_valid, proj_last, proj_data}, {1'b1, prev_last, prev_data});
         if (exp_q.size() == 0) begin
            check("valid_when_idle", proj_valid, 0);
         end else if (!proj_valid) begin
            wait_cnt++;
            if (wait_cnt > 2) check("valid_latency", proj_valid, 1);
         end else begin
            wait_cnt = 0;
            check("data", proj_data, exp_q[0]);
            check("last", proj_last, exp_q.size() == 1);
            if (proj_ready) begin
               log_d.push_back(proj_data);
               log_l.push_back(proj_last);
               void'(exp_q.pop_front());
            end
         end
         prev_stall = proj_valid && !proj_ready && !start;
         prev_data  = proj_data;
         prev_last  = proj_last;
         // Inputs of this cycle take effect at the coming rising edge.
         if (wr_en) begin
            if (write_projection < 64) begin
               mdl_mem[wp][write_projection] = projection_calc;
               if (cnt < 64) cnt++;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         exp_drop = start && (exp_q.size() > 0);
         if (start) begin
            exp_q.delete();
            for (int i = 0; i < cnt; i++) exp_q.push_back(mdl_mem[wp][i]);
            wp = 1 - wp;
            cnt = 0;
            wait_cnt = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int addr, input logic [DB-1:0] d);
      wr_en = 1'b1; write_projection = addr[8:0]; projection_calc = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic clear_log();
      log_d.delete();
      log_l.delete();
   endtask

   initial begin
      logic [0:0] pat [5];
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; write_projection = '0;
      projection_calc = '0; proj_ready = 1'b0;
      run(3);
      reset = 1'b0;
      run(2);

      // Basic event: A, B, C streamed back-to-back, last on C.
      clear_log();
      do_write(0, 54'hA); do_write(1, 54'hB); do_write(2, 54'hC);
      proj_ready = 1'b1;
      do_start();
      run(6);
      check("t1_count", log_d.size(), 3);
      if (log_d.size() == 3) begin
         check("t1_w0", {log_l[0], log_d[0]}, {1'b0, 54'hA});
         check("t1_w1", {log_l[1], log_d[1]}, {1'b0, 54'hB});
         check("t1_w2", {log_l[2], log_d[2]}, {1'b1, 54'hC});
      end
      check("t1_idle_valid", proj_valid, 0);

      // Backpressure 1,0,0,1,1: words held while stalled.
      clear_log();
      do_write(0, 54'hA); do_write(1, 54'hB); do_write(2, 54'hC);
      proj_ready = 1'b0;
      do_start();
      cyc();
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         proj_ready = pat[i];
         cyc();
      end
      proj_ready = 1'b1;
      run(3);
      check("t2_count", log_d.size(), 3);
      if (log_d.size() == 3) begin
         check("t2_w0", log_d[0], 54'hA);
         check("t2_w1", log_d[1], 54'hB);
         check("t2_w2", {log_l[2], log_d[2]}, {1'b1, 54'hC});
      end

      // Out-of-range write: discarded, overflow sticks.
      clear_log();
      do_write(0, 54'h11); do_write(64, 54'hBAD); do_write(1, 54'h22);
      check("t3_overflow", overflow, 1);
      do_start();
      run(5);
      check("t3_count", log_d.size(), 2);
      if (log_d.size() == 2) begin
         check("t3_w0", log_d[0], 54'h11);
         check("t3_w1", {log_l[1], log_d[1]}, {1'b1, 54'h22});
      end

      // Abandon event A after two handshakes; event B drains fully.
      clear_log();
      drop_count = 0;
      for (int i = 0; i < 5; i++) do_write(i, 54'h100 + 54'(i));
      proj_ready = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) do_write(i, 54'h200 + 54'(i));
      proj_ready = 1'b1;
      run(2);
      proj_ready = 1'b0;
      do_start();
      proj_ready = 1'b1;
      run(8);
      check("t4_drops", drop_count, 1);
      check("t4_count", log_d.size(), 5);
      if (log_d.size() == 5) begin
         check("t4_w0", log_d[0], 54'h100);
         check("t4_w1", log_d[1], 54'h101);
         check("t4_w2", log_d[2], 54'h200);
         check("t4_w3", log_d[3], 54'h201);
         check("t4_w4", {log_l[4], log_d[4]}, {1'b1, 54'h202});
      end

      // Write coinciding with start belongs to the outgoing event.
      clear_log();
      do_write(0, 54'h300);
      wr_en = 1'b1; write_projection = 9'd1; projection_calc = 54'h301;
      do_start();
      wr_en = 1'b0;
      run(5);
      check("t5_count", log_d.size(), 2);
      if (log_d.size() == 2) begin
         check("t5_w0", {log_l[0], log_d[0]}, {1'b0, 54'h300});
         check("t5_w1", {log_l[1], log_d[1]}, {1'b1, 54'h301});
      end

      // Empty event: nothing emitted.
      clear_log();
      do_start();
      run(4);
      check("t6_empty_valid", proj_valid, 0);
      check("t6_empty_count", log_d.size(), 0);

      // Reset mid-drain: outputs drop at once, silence until next start.
      for (int i = 0; i < 4; i++) do_write(i, 54'h500 + 54'(i));
      proj_ready = 1'b0;
      do_start();
      run(3);
      check("t7_pre_valid", proj_valid, 1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("t7_async_valid", proj_valid, 0);
      check("t7_async_overflow", overflow, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      proj_ready = 1'b1;
      run(5);
      check("t7_silent", log_d.size(), 0);
      do_write(0, 54'h400);
      do_start();
      run(4);
      check("t7_after_count", log_d.size(), 1);
      if (log_d.size() == 1)
         check("t7_after_w0", {log_l[0], log_d[0]}, {1'b1, 54'h400});

      run(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/projection_receiver.md
PROJECTION_RECEIVER -- requirements
Module: projection_receiver

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6, giving log2 of entries per page (64).
REQ-002 SHALL have parameter DATA_BITS, default 54, giving projection word width.
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle event boundary pulse.
REQ-006 SHALL have port wr_en, input, 1, projection write strobe from the projection calculator.
REQ-007 SHALL have port write_projection, input, 9, write address.
REQ-008 SHALL have port projection_calc, input, DATA_BITS, write data.
REQ-009 SHALL have port proj_data, output, DATA_BITS, registered projection word presented downstream.
REQ-010 SHALL have port proj_valid, output, 1, proj_data holds a valid entry.
REQ-011 SHALL have port proj_ready, input, 1, downstream accepts when proj_valid and proj_ready are both high.
REQ-012 SHALL have port proj_last, output, 1, qualifies the final entry of an event.
REQ-013 SHALL have port overflow, output, 1, sticky flag for discarded writes.
REQ-014 SHALL have port dropped, output, 1, one-cycle pulse when an undrained event is abandoned.

Function
REQ-015 SHALL store projections in a two-page buffer, each page 2^ADDR_BITS x DATA_BITS; one page is the write page and the other is the read page.
REQ-016 SHALL write projection_calc to write-page location write_projection[ADDR_BITS-1:0] on any cycle with wr_en=1 and write_projection < 2^ADDR_BITS.
REQ-017 SHALL increment the write counter on each accepted write, saturating at 2^ADDR_BITS.
REQ-018 SHALL discard any write with write_projection >= 2^ADDR_BITS, leave the counter unchanged, and set overflow until reset.
REQ-019 SHALL, on start, swap the pages, latch the write counter (including any write accepted in the same cycle) as the read count, and clear the write counter to 0.
REQ-020 SHALL direct writes in the cycle after start to the new write page.
REQ-021 SHALL implement states IDLE and DRAIN: IDLE->DRAIN on start with a latched count > 0; IDLE->IDLE on start with a latched count of 0; DRAIN->IDLE after the handshake of the last entry.
REQ-022 SHALL, in DRAIN, read addresses 0..count-1 in ascending order from the read page using synchronous memory reads.
REQ-023 SHALL assert proj_valid no later than 2 cycles after the start edge that enters DRAIN.
REQ-024 SHALL, with proj_ready held high, sustain one entry per cycle.
REQ-025 SHALL hold proj_data, proj_valid and proj_last stable while proj_valid=1 and proj_ready=0.
REQ-026 SHALL assert proj_last together with proj_valid only for entry count-1.
REQ-027 SHALL deassert proj_valid in the cycle after the last handshake when no new event is pending.
REQ-028 SHALL, on start while in DRAIN, pulse dropped for one cycle, abandon the remaining entries, deassert proj_valid in the next cycle, and begin draining the newly swapped page under REQ-019/REQ-021.
REQ-029 SHALL never present a stale entry from the abandoned event after the cycle following the start that abandoned it.

Reset
REQ-030 SHALL, on reset assertion, immediately force proj_valid=0, proj_last=0, overflow=0, dropped=0, proj_data=0, state=IDLE, write counter=0, read count=0, and write page=0.
REQ-031 SHALL not clear memory contents on reset.
REQ-032 SHALL, after reset deasserts mid-drain, emit nothing until a subsequent start.

Verification
REQ-033 SHALL be verified by: writes to addresses 0,1,2 with data 0xA,0xB,0xC, then start, proj_ready=1 -> 0xA,0xB,0xC on consecutive cycles with proj_last only on 0xC, then proj_valid=0.
REQ-034 SHALL be verified by: the same event with proj_ready toggling 1,0,0,1,1 -> each word held while stalled, no loss or duplication.
REQ-035 SHALL be verified by: a write to address 64 (0x40) -> overflow=1, count unchanged, the word never appears downstream.
REQ-036 SHALL be verified by: event A with 5 entries, start after 2 handshakes with event B of 3 entries written -> dropped pulses once, then B's 3 words are output and A's remaining 3 words never appear.
REQ-037 SHALL be verified by: wr_en in the same cycle as start -> that word is output as the last word of the outgoing event.
REQ-038 SHALL be verified by: start with 0 writes -> proj_valid stays 0 and state remains IDLE; reset asserted mid-drain -> proj_valid=0 immediately and no output until the next start.
